// File: rtl/arith_unit_32.sv
// arith_unit_32: arithmetic core of the Mini-SRC ALU.
//   Combinational add / sub / neg / not with carry-out, and a combinational
//   signed 32x32->64 radix-4 Booth multiplier.
//   Sequential signed 32/32 restoring divider that returns {remainder, quotient}.
// Ports:
//   clk          rising-edge clock (divider only)
//   in_reset_n   asynchronous active-low reset
//   in_a, in_b   operands (dividend / divisor for DIV)
//   in_opcode    operation select
//   in_start     starts a division (opcode DIV, divider idle)
//   out_result   64-bit result
//   out_carry    adder carry-out of the top bit
//   out_busy     divider running
//   out_done     one-cycle pulse when the division result is valid
module arith_unit_32 #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 in_reset_n,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [3:0]           in_opcode,
    input  logic                 in_start,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_carry,
    output logic                 out_busy,
    output logic                 out_done
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned CW = $clog2(DIV_CYCLES);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } div_state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [RW-1:0] neg_r(input logic [RW-1:0] x);
        return ~x + RW'(1);
    endfunction

    // ---------------------------------------------------------------
    // Adder: a single carry chain shared by ADD/SUB/NEG/NOT
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [SW-1:0]    add_sum;

    always_comb begin
        add_a   = in_a;
        add_b   = in_b;
        add_cin = 1'b0;
        unique case (in_opcode)
            OP_SUB: begin
                add_b   = ~in_b;
                add_cin = 1'b1;
            end
            OP_NEG: begin
                add_a   = '0;
                add_b   = ~in_b;
                add_cin = 1'b1;
            end
            OP_NOT: begin
                add_a   = '0;
                add_b   = ~in_b;
            end
            default: ;
        endcase
        add_sum = {1'b0, add_a} + {1'b0, add_b} + SW'(add_cin);
    end

    // ---------------------------------------------------------------
    // Multiplier: radix-4 Booth, one partial product per bit pair of B
    // ---------------------------------------------------------------
    logic [WIDTH:0]   b_pad;
    logic [RW-1:0]    a_ext;
    logic [RW-1:0]    pp;
    logic [RW-1:0]    mul_prod;
    logic [2:0]       trip;

    always_comb begin
        b_pad    = {in_b, 1'b0};
        a_ext    = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        pp       = '0;
        trip     = '0;
        mul_prod = '0;
        for (int i = 0; i < int'(WIDTH / 2); i++) begin
            trip = b_pad[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = neg_r(a_ext << 1);
                3'b101, 3'b110: pp = neg_r(a_ext);
                default:        pp = '0;
            endcase
            mul_prod = mul_prod + (pp << (2 * i));
        end
    end

    // ---------------------------------------------------------------
    // Divider: unsigned restoring divide on magnitudes, signs fixed last
    // ---------------------------------------------------------------
    div_state_t       state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [WIDTH-1:0] rem_q, rem_nxt;
    logic [WIDTH-1:0] quo_q, quo_nxt;
    logic [WIDTH-1:0] dvs_q, dvs_nxt;
    logic             a_neg_q, a_neg_nxt;
    logic             q_neg_q, q_neg_nxt;
    logic             dbz_q, dbz_nxt;
    logic [WIDTH-1:0] res_q_q, res_q_nxt;
    logic [WIDTH-1:0] res_r_q, res_r_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [SW-1:0]    rem_shift;

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
            dbz_q   <= 1'b0;
            res_q_q <= '0;
            res_r_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            rem_q   <= rem_nxt;
            quo_q   <= quo_nxt;
            dvs_q   <= dvs_nxt;
            a_neg_q <= a_neg_nxt;
            q_neg_q <= q_neg_nxt;
            dbz_q   <= dbz_nxt;
            res_q_q <= res_q_nxt;
            res_r_q <= res_r_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        rem_nxt   = rem_q;
        quo_nxt   = quo_q;
        dvs_nxt   = dvs_q;
        a_neg_nxt = a_neg_q;
        q_neg_nxt = q_neg_q;
        dbz_nxt   = dbz_q;
        res_q_nxt = res_q_q;
        res_r_nxt = res_r_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        rem_shift = {rem_q, quo_q[WIDTH-1]};

        unique case (state_q)
            S_IDLE: begin
                if (in_start && (in_opcode == OP_DIV)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    rem_nxt   = '0;
                    quo_nxt   = in_a[WIDTH-1] ? neg_w(in_a) : in_a;
                    dvs_nxt   = in_b[WIDTH-1] ? neg_w(in_b) : in_b;
                    a_neg_nxt = in_a[WIDTH-1];
                    q_neg_nxt = in_a[WIDTH-1] ^ in_b[WIDTH-1];
                    dbz_nxt   = (in_b == '0);
                    busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                // One quotient bit per edge; quo_q doubles as the dividend shifter.
                if (rem_shift >= {1'b0, dvs_q}) begin
                    rem_nxt = WIDTH'(rem_shift - {1'b0, dvs_q});
                    quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_nxt = rem_shift[WIDTH-1:0];
                    quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt_q + CW'(1);
                if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                // Divide by zero: remainder magnitude is |A|, so the usual
                // dividend-sign fixup restores A; only the quotient is forced.
                res_q_nxt = dbz_q ? '1 : (q_neg_q ? neg_w(quo_q) : quo_q);
                res_r_nxt = a_neg_q ? neg_w(rem_q) : rem_q;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Result select
    // ---------------------------------------------------------------
    always_comb begin
        out_result = '0;
        out_carry  = 1'b0;
        unique case (in_opcode)
            OP_ADD, OP_SUB, OP_NEG, OP_NOT: begin
                out_result = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                out_carry  = add_sum[WIDTH];
            end
            OP_MUL: out_result = mul_prod;
            OP_DIV: out_result = {res_r_q, res_q_q};
            default: ;
        endcase
    end

    assign out_busy = busy_q;
    assign out_done = done_q;

endmodule

// File: tb/tb_arith_unit_32.sv
// tb_arith_unit_32: randomized self-checking bench for arith_unit_32.
//   Combinational ops and divider results are compared against a
//   behavioural model built from plain integer arithmetic.
module tb_arith_unit_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        start;
    logic [63:0] res;
    logic        carry;
    logic        busy;
    logic        done;

    int n_chk;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arith_unit_32 dut (
        .clk        (clk),
        .in_reset_n (rst_n),
        .in_a       (a),
        .in_b       (b),
        .in_opcode  (op),
        .in_start   (start),
        .out_result (res),
        .out_carry  (carry),
        .out_busy   (busy),
        .out_done   (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference for non-divider ops: returns {carry, result}
    function automatic logic [64:0] ref_comb(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r32;
        longint      p;
        case (o)
            4'b0000: begin
                p = longint'({32'd0, x}) + longint'({32'd0, y});
                return {p[32], 32'd0, p[31:0]};
            end
            4'b0001: begin
                r32 = x - y;
                return {(x >= y), 32'd0, r32};
            end
            4'b1000: begin
                p = longint'($signed(x)) * longint'($signed(y));
                return {1'b0, p};
            end
            4'b1010: begin
                r32 = 32'd0 - y;
                return {(y == 32'd0), 32'd0, r32};
            end
            4'b1011: begin
                r32 = ~y;
                return {1'b0, 32'd0, r32};
            end
            default: return 65'd0;
        endcase
    endfunction

    // Reference divider: returns {remainder, quotient}
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint q;
        longint r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        return {r[31:0], q[31:0]};
    endfunction

    task automatic comb_vec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [64:0] e;
        op = o;
        a  = x;
        b  = y;
        #1;
        e = ref_comb(o, x, y);
        check({tag, "_res"}, res, e[63:0]);
        check({tag, "_cy"}, 64'(carry), 64'(e[64]));
    endtask

    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input bit perturb, input string tag);
        logic [63:0] e;
        logic        bad_seen;
        e        = ref_div(x, y);
        bad_seen = 1'b0;
        op       = 4'b1001;
        a        = x;
        b        = y;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        for (int k = 1; k <= 32; k++) begin
            if (perturb && k == 5) begin
                a     = ~x;
                b     = y + 32'd3;
                start = 1'b1;
            end
            if (perturb && k == 7) start = 1'b0;
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) bad_seen = 1'b1;
        end
        check({tag, "_run_hs"}, 64'(bad_seen), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done"}, 64'({busy, done}), 64'b01);
        check({tag, "_res"}, res, e);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_hold"}, res, e);
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic        got_done;

        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 4'b1001;
        a     = '0;
        b     = '0;

        // Reset state and combinational path during reset
        #12;
        check("rst_busy_done", 64'({busy, done}), 64'b00);
        check("rst_div_res", res, 64'd0);
        comb_vec(4'b0000, 32'd1, 32'd2, "rst_add");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed combinational vectors
        comb_vec(4'b0000, 32'h0000_FFFF, 32'h0000_0001, "add1");
        comb_vec(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
        comb_vec(4'b0001, 32'h0000_FFFF, 32'h0000_00FF, "sub1");
        comb_vec(4'b1010, 32'h0, 32'h0000_0001, "neg1");
        comb_vec(4'b1010, 32'h0, 32'h0, "neg0");
        comb_vec(4'b1011, 32'h0, 32'hABCD_ABCD, "not1");
        comb_vec(4'b0110, 32'h1234_5678, 32'h9ABC_DEF0, "illegal");
        comb_vec(4'b1000, 32'hFFFF_FFF3, 32'h0000_000B, "mul_neg");
        comb_vec(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1");
        comb_vec(4'b1000, 32'h8000_0000, 32'h8000_0000, "mul_min");
        comb_vec(4'b1000, 32'h7FFF_FFFF, 32'h8000_0000, "mul_maxmin");

        // Randomized combinational ops, including unused opcodes
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: o = 4'b0000;
                1: o = 4'b0001;
                2: o = 4'b1000;
                3: o = 4'b1010;
                4: o = 4'b1011;
                default: o = 4'($urandom_range(0, 15));
            endcase
            if (o == 4'b1001) o = 4'b0000;
            comb_vec(o, $urandom, $urandom, "rnd_comb");
        end

        // Directed divisions
        @(posedge clk);
        #1;
        run_div(32'd34, 32'd36, 1'b0, "div_34_36");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        run_div(32'd5, 32'd0, 1'b0, "div_by0");
        run_div(32'hFFFF_FFF9, 32'd0, 1'b0, "div_neg_by0");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_div(32'd100, 32'hFFFF_FFF9, 1'b0, "div_100_m7");

        // Reset in the middle of a division
        op    = 4'b1001;
        a     = 32'd1000;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy_done", 64'({busy, done}), 64'b00);
        check("midrst_res", res, 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        got_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) got_done = 1'b1;
        end
        check("midrst_no_done", 64'(got_done), 64'd0);
        check("midrst_res_after", res, 64'd0);
        run_div(32'd1000, 32'd7, 1'b0, "div_after_rst");

        // Randomized divisions, biased toward small and zero divisors
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'($urandom_range(0, 4));
                1: y = 32'd0 - 32'($urandom_range(1, 4));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) x = x >> $urandom_range(0, 31);
            run_div(x, y, i[0], "rnd_div");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/arith_unit_32.md
Name: arith_unit_32

Overview:
32-bit arithmetic unit for the Mini-SRC datapath ALU. It provides combinational add/sub/neg/not (ripple or CLA adder core) and a combinational signed 32x32->64 multiplier. It also contains a sequential signed 32/32 divider that produces quotient and remainder.
The ALU top-level muxes its 64-bit result alongside the shift/logic results.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH. Only 32 is required to be supported.
DIV_CYCLES, 32, divider iteration count; must equal WIDTH.

Ports:
clk  input  1  rising-edge clock (used only by the divider)
in_reset_n  input  1  asynchronous active-low reset
in_a  input  32  operand A; dividend for DIV
in_b  input  32  operand B; divisor for DIV
in_opcode  input  4  operation select
in_start  input  1  starts a division when opcode is DIV and the divider is idle
out_result  output  64  result
out_carry  output  1  adder carry-out
out_busy  output  1  divider running
out_done  output  1  one-cycle pulse when the division result is valid

Behaviour:
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A+~B+1.
  - 1000 MUL: signed A*B.
  - 1001 DIV: signed A/B.
  - 1010 NEG: 0+~B+1.
  - 1011 NOT: 0+~B+0, i.e. ~B.
  - Every other opcode: out_result = 0 and out_carry = 0.
- Adder ops (0000, 0001, 1010, 1011):
  - Purely combinational.
  - out_result[31:0] = 32-bit sum; out_result[63:32] = 0.
  - out_carry = carry-out of bit 31. It is 0 for non-adder opcodes.
- MUL:
  - Combinational two's-complement 64-bit product; the full 64 bits are valid.
  - Any structure is allowed (Booth recoding preferred).
- DIV:
  - out_result = {remainder, quotient}, driven from internal registers.
  - Quotient truncates toward zero. Remainder has the sign of the dividend, or is zero.
  - Signed operands are handled by taking magnitudes, running an unsigned restoring or non-restoring divide, then fixing signs.
- Divider handshake:
  - in_start is sampled on a rising edge only when in_opcode = 1001 and out_busy = 0. That edge latches in_a and in_b and sets out_busy.
  - Changes to in_a/in_b while busy are ignored. in_start while busy is ignored.
  - Exactly DIV_CYCLES (32) iteration edges follow the start edge.
  - On the 33rd edge after start: result registers are updated with sign fixup applied, out_busy clears, and out_done is high for exactly one cycle.
  - The result registers hold their value until the next accepted start. A new start may be accepted on the same edge that out_done falls.
- Divide by zero (B = 0):
  - Same latency as a normal division.
  - quotient = 32'hFFFFFFFF, remainder = dividend A.
- Overflow case (A = 32'h80000000, B = 32'hFFFFFFFF):
  - quotient = 32'h80000000, remainder = 0.
- Reset (in_reset_n low, asynchronous):
  - out_busy = 0, out_done = 0, divider result registers = 0, iteration counter = 0.
  - Asserting reset mid-division aborts the division; no done pulse is produced.
  - After release, reading with opcode 1001 shows out_result = 0.
- While in_reset_n is low, the combinational ops still reflect their inputs.

Test Plan:
- ADD: A=0000FFFF, B=00000001 -> out_result=00000000_00010000, carry 0. ADD: A=FFFFFFFF, B=1 -> result 0, carry 1.
- SUB: A=0000FFFF, B=000000FF -> 00000000_0000FF00. NEG: B=1 -> 00000000_FFFFFFFF. NOT: B=ABCDABCD -> 00000000_54325432. Opcode 0110 -> 0.
- MUL: A=FFFFFFF3, B=0000000B -> FFFFFFFF_FFFFFF71. MUL: A=FFFFFFFF, B=FFFFFFFF -> 00000000_00000001.
- DIV, start with A=34, B=36:
  - out_busy holds for 32 cycles; out_done pulses on the 33rd edge.
  - Result 00000022_00000000.
  - DIV A=-7 (FFFFFFF9), B=2 -> FFFFFFFF_FFFFFFFD.
  - in_start while busy is ignored; changing in_a mid-run has no effect.
- DIV by zero:
  - A=5, B=0 -> 00000005_FFFFFFFF after 33 edges.
  - A=80000000, B=FFFFFFFF -> 00000000_80000000.
- Reset: pull in_reset_n low at iteration 10 of a division -> busy/done drop immediately, out_result (DIV) = 0, no done pulse. A subsequent division completes normally.
